// File: rtl/bcharger_pkg.sv
// Shared constants and types for the bcharger comparator front end.
// Channel indices map cmp_raw bits to the filtered level outputs.
package bcharger_pkg;

    localparam int unsigned CH_VTRKL  = 0;
    localparam int unsigned CH_VTERM  = 1;
    localparam int unsigned CH_ITERM  = 2;
    localparam int unsigned CH_VRCHRG = 3;
    localparam int unsigned NCH       = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN
    } cmpfilt_state_t;

endpackage

// File: rtl/bcharger_deglitch.sv
// One comparator channel: synchroniser followed by a consecutive-sample deglitch filter.
// f_next exposes the value f takes on the coming edge so the top can flag changes without lag.
module bcharger_deglitch
    import bcharger_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic raw,
    output logic f,
    output logic f_next
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    // Synchroniser keeps running regardless of en so the level is fresh on re-enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    always_comb begin
        f_next = f;
        if (en && (s != f) && (cnt == CNT_MAX)) begin
            f_next = s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            f   <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
        end else if (s == f) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            f   <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bcharger_cmpfilt.sv
// Comparator conditioning for the bcharger FSM: four deglitched levels plus
// a settle qualifier, a change strobe and a vterm/vrchrg consistency flag.
module bcharger_cmpfilt
    import bcharger_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] cmp_raw,
    output logic       vtrkl,
    output logic       vterm,
    output logic       iterm,
    output logic       vrchrg,
    output logic       valid,
    output logic       chg_evt,
    output logic       err_incons
);

    localparam int unsigned SETTLE_LEN = SYNC_STAGES + DEB_CYCLES;
    localparam int unsigned SW         = $clog2(SETTLE_LEN);
    // The IDLE->SETTLE edge is the first of the settle window, so SETTLE sees LEN-1 more edges.
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN - 2);

    cmpfilt_state_t   state;
    cmpfilt_state_t   state_next;
    logic [SW-1:0]    settle_cnt;
    logic [NCH-1:0]   f;
    logic [NCH-1:0]   f_next;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        bcharger_deglitch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deglitch (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .raw   (cmp_raw[i]),
            .f     (f[i]),
            .f_next(f_next[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = SETTLE;
                SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        valid = (state == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (en && (state == SETTLE)) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg_evt    <= 1'b0;
            err_incons <= 1'b0;
        end else begin
            chg_evt <= (state == RUN) && (f_next != f);
            if (!en) begin
                err_incons <= 1'b0;
            end else if ((state == RUN) && f_next[CH_VTERM] && f_next[CH_VRCHRG]) begin
                err_incons <= 1'b1;
            end
        end
    end

    assign vtrkl  = f[CH_VTRKL];
    assign vterm  = f[CH_VTERM];
    assign iterm  = f[CH_ITERM];
    assign vrchrg = f[CH_VRCHRG];

endmodule
